cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for a soft CPU: fills instruction memory with NOPs, accepts a
// streamed program, runs the CPU until a cycle or PC limit, then holds it halted.
module cpu_run_ctrl #(
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0020,
  parameter int          MAX_CYCLES = 20000,
  parameter int          PC_LIMIT   = 100,
  parameter int          CYC_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  input  logic [31:0]      cpu_pc,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles
);

  localparam int                FILL_W     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(IMEM_DEPTH - 1);
  localparam logic [32:0]       IMEM_BYTES = {IMEM_DEPTH[30:0], 2'b00};
  localparam logic [CYC_W-1:0]  CYC_LIMIT  = CYC_W'(MAX_CYCLES);
  localparam logic [31:0]       PC_LIM     = PC_LIMIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic               wr_valid_q, wr_valid_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               last_seen_q, last_seen_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic [1:0]         cause_q, cause_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               handshake;
  logic               bad_addr;
  logic               cyc_hit;
  logic               pc_hit;

  assign ld_ready   = (state_q == S_LOAD) && !last_seen_q;
  assign handshake  = ld_ready && ld_valid;
  assign bad_addr   = (ld_addr[1:0] != 2'b00) || ({1'b0, ld_addr} >= IMEM_BYTES);
  assign cyc_hit    = (cycles_q == CYC_LIMIT);
  assign pc_hit     = ({2'b00, cpu_pc[31:2]} > PC_LIM);

  assign imem_we    = (state_q == S_FILL) || ((state_q == S_LOAD) && wr_valid_q);
  assign imem_addr  = (state_q == S_FILL) ? 32'({fill_cnt_q, 2'b00}) : wr_addr_q;
  assign imem_wdata = (state_q == S_FILL) ? NOP_WORD : wr_data_q;
  assign cpu_rst_n  = (state_q == S_RUN) || (state_q == S_HALT);
  assign cpu_en     = (state_q == S_RUN);
  assign halt       = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cycles     = cycles_q;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    last_seen_d = last_seen_q;
    cycles_d    = cycles_q;
    cause_d     = cause_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FILL;
          fill_cnt_d  = '0;
          last_seen_d = 1'b0;
          cycles_d    = '0;
          cause_d     = 2'b00;
          err_d       = 1'b0;
        end
      end
      S_FILL: begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
        if (fill_cnt_q == FILL_LAST) begin
          state_d     = S_LOAD;
          last_seen_d = 1'b0;
        end
      end
      S_LOAD: begin
        // The final write is issued during the cycle after the last handshake.
        if (last_seen_q) begin
          state_d  = S_RUN;
          cycles_d = '0;
        end else if (handshake) begin
          if (bad_addr) begin
            err_d = 1'b1;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ld_addr;
            wr_data_d  = ld_data;
          end
          if (ld_last) begin
            last_seen_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cyc_hit || pc_hit) begin
          cause_d = {pc_hit, cyc_hit};
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + CYC_W'(1);
        end
      end
      S_HALT: begin
        if (start) begin
          state_d     = S_FILL;
          fill_cnt_d  = '0;
          last_seen_d = 1'b0;
          cycles_d    = '0;
          cause_d     = 2'b00;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a write captured this cycle.
    if (abort) begin
      state_d     = S_IDLE;
      fill_cnt_d  = '0;
      wr_valid_d  = 1'b0;
      last_seen_d = 1'b0;
      cycles_d    = '0;
      cause_d     = 2'b00;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_cnt_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      last_seen_q <= 1'b0;
      cycles_q    <= '0;
      cause_q     <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      last_seen_q <= last_seen_d;
      cycles_q    <= cycles_d;
      cause_q     <= cause_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table-driven load/run vectors, randomized programs and
// PC traces checked against a behavioural model, plus abort/reset corner cases.
module tb_cpu_run_ctrl;

  localparam int          DEPTH = 128;
  localparam int          MAXC  = 50;
  localparam int          PCL   = 100;
  localparam logic [31:0] NOP   = 32'h0000_0020;

  logic        clk, rst, start, abort;
  logic        ld_valid, ld_ready, ld_last;
  logic [31:0] ld_addr, ld_data;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        cpu_rst_n, cpu_en;
  logic [31:0] cpu_pc;
  logic        halt, done, err;
  logic [1:0]  halt_cause;
  logic [31:0] cycles;

  int total;
  int bad_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    bit          exp_we;
    bit          exp_err;
  } ld_vec_t;

  typedef struct {
    int         k;
    logic [1:0] exp_cause;
    int         exp_cycles;
  } run_vec_t;

  ld_vec_t  prog[$];
  run_vec_t run_tbl[5];

  cpu_run_ctrl #(
    .IMEM_DEPTH(DEPTH),
    .NOP_WORD  (NOP),
    .MAX_CYCLES(MAXC),
    .PC_LIMIT  (PCL),
    .CYC_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .cpu_en    (cpu_en),
    .cpu_pc    (cpu_pc),
    .halt      (halt),
    .halt_cause(halt_cause),
    .done      (done),
    .err       (err),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_halt"},      32'(halt),       0);
    checkOutput({tag, "_cause"},     32'(halt_cause), 0);
    checkOutput({tag, "_done"},      32'(done),       0);
    checkOutput({tag, "_err"},       32'(err),        0);
    checkOutput({tag, "_cycles"},    cycles,          0);
    checkOutput({tag, "_imem_we"},   32'(imem_we),    0);
    checkOutput({tag, "_ld_ready"},  32'(ld_ready),   0);
    checkOutput({tag, "_cpu_en"},    32'(cpu_en),     0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),  0);
  endtask

  function automatic bit isBad(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  // Called on the first FILL cycle; expects word i of DEPTH NOP writes at byte 4*i.
  task automatic checkFill();
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (imem_we !== 1'b1 || imem_addr !== 32'(i * 4) || imem_wdata !== NOP ||
          ld_ready !== 1'b0 || cpu_rst_n !== 1'b0)
        errs++;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("fill_bad_words", errs, 0);
    checkOutput("fill_then_ready", 32'(ld_ready), 1);
    checkOutput("fill_then_no_we", 32'(imem_we), 0);
  endtask

  task automatic buildRandomProg();
    int  n;
    bit  err_m;
    logic [31:0] a;
    prog.delete();
    n     = $urandom_range(1, 6);
    err_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        6:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        7:       a = 32'(4 * DEPTH);
        8:       a = 32'(4 * DEPTH - 4);
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      err_m = err_m | isBad(a);
      prog.push_back('{a, $urandom, (i == n - 1), !isBad(a), err_m});
    end
  endtask

  // Streams prog[] with random gaps; ends on the first RUN cycle.
  task automatic runLoad();
    for (int i = 0; i < prog.size(); i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        ld_addr  = $urandom;
        ld_data  = $urandom;
        ld_last  = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      checkOutput("load_ready", 32'(ld_ready), 1);
      ld_valid = 1'b1;
      ld_addr  = prog[i].addr;
      ld_data  = prog[i].data;
      ld_last  = prog[i].last;
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      start    = 1'b0;
      checkOutput("load_we", 32'(imem_we), 32'(prog[i].exp_we));
      if (prog[i].exp_we) begin
        checkOutput("load_addr", imem_addr, prog[i].addr);
        checkOutput("load_data", imem_wdata, prog[i].data);
      end
      checkOutput("load_err", 32'(err), 32'(prog[i].exp_err));
      if (prog[i].last)
        checkOutput("load_ready_drop", 32'(ld_ready), 0);
    end
    @(negedge clk);
    checkOutput("run_cpu_rst_n", 32'(cpu_rst_n), 1);
    checkOutput("run_cpu_en", 32'(cpu_en), 1);
    checkOutput("run_cycles0", cycles, 0);
    checkOutput("run_no_we", 32'(imem_we), 0);
  endtask

  // PC word stays within the limit before cycle k and exceeds it from k on.
  task automatic runCheck(input int k, input logic [1:0] exp_cause, input int exp_cycles);
    int c = 0;
    int errs = 0;
    int word;
    while (halt !== 1'b1 && c < 200) begin
      if (cycles !== 32'(c) || cpu_en !== 1'b1) errs++;
      if (c == k)
        cpu_pc = 32'(PCL + 1) * 4;
      else if (c > k) begin
        word   = PCL + 1 + (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1000)));
        cpu_pc = 32'(word) * 4 + 32'($urandom_range(0, 3));
      end else begin
        word   = ($urandom_range(0, 3) == 0) ? PCL : int'($urandom_range(0, PCL));
        cpu_pc = 32'(word) * 4 + 32'($urandom_range(0, 3));
      end
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    checkOutput("run_count_bad", errs, 0);
    checkOutput("halt", 32'(halt), 1);
    checkOutput("halt_cause", 32'(halt_cause), 32'(exp_cause));
    checkOutput("halt_cycles", cycles, 32'(exp_cycles));
    checkOutput("run_len", 32'(c - 1), 32'(exp_cycles));
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("halt_cpu_en", 32'(cpu_en), 0);
    checkOutput("halt_cpu_rst_n", 32'(cpu_rst_n), 1);
    checkOutput("halt_err", 32'(err), 32'(prog[prog.size() - 1].exp_err));
    cpu_pc = $urandom;
    @(negedge clk);
    checkOutput("done_once", 32'(done), 0);
    checkOutput("halt_held", 32'(halt), 1);
    checkOutput("halt_cycles_frozen", cycles, 32'(exp_cycles));
    checkOutput("halt_cause_frozen", 32'(halt_cause), 32'(exp_cause));
  endtask

  task automatic restartFromHalt();
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_halt", 32'(halt), 0);
    checkOutput("restart_cause", 32'(halt_cause), 0);
    checkOutput("restart_err", 32'(err), 0);
    checkOutput("restart_cycles", cycles, 0);
    checkFill();
  endtask

  initial begin
    int          k;
    int          hc;
    logic [1:0]  cause_m;

    total    = 0;
    bad_cnt  = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_last  = 1'b0;
    cpu_pc   = '0;

    run_tbl[0] = '{1000, 2'b01, 50};
    run_tbl[1] = '{10,   2'b10, 10};
    run_tbl[2] = '{50,   2'b11, 50};
    run_tbl[3] = '{0,    2'b10, 0};
    run_tbl[4] = '{49,   2'b10, 49};

    repeat (2) @(negedge clk);
    checkReset("por");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_we", 32'(imem_we), 0);

    applyStimulus(1'b1, 1'b1);
    checkOutput("start_abort_we", 32'(imem_we), 0);
    checkOutput("start_abort_rstn", 32'(cpu_rst_n), 0);
    @(negedge clk);
    checkOutput("start_abort_we2", 32'(imem_we), 0);

    applyStimulus(1'b1, 1'b0);
    checkFill();
    prog.delete();
    prog.push_back('{32'd0,   32'h2008_0001, 1'b0, 1'b1, 1'b0});
    prog.push_back('{32'd6,   32'h2009_0002, 1'b0, 1'b0, 1'b1});
    prog.push_back('{32'd512, 32'h200a_0003, 1'b0, 1'b0, 1'b1});
    prog.push_back('{32'd4,   32'h200b_0004, 1'b0, 1'b1, 1'b1});
    prog.push_back('{32'd76,  32'h0800_0013, 1'b1, 1'b1, 1'b1});
    runLoad();
    runCheck(run_tbl[0].k, run_tbl[0].exp_cause, run_tbl[0].exp_cycles);

    for (int r = 1; r < 5; r++) begin
      restartFromHalt();
      buildRandomProg();
      runLoad();
      runCheck(run_tbl[r].k, run_tbl[r].exp_cause, run_tbl[r].exp_cycles);
    end

    for (int r = 0; r < 6; r++) begin
      k       = $urandom_range(0, 70);
      hc      = (k < MAXC) ? k : MAXC;
      cause_m = {k <= hc, hc == MAXC};
      restartFromHalt();
      buildRandomProg();
      runLoad();
      runCheck(k, cause_m, hc);
    end

    // Abort mid-LOAD with a handshake in the same cycle.
    restartFromHalt();
    ld_valid = 1'b1;
    ld_addr  = 32'd6;
    ld_data  = 32'h1111_1111;
    @(negedge clk);
    ld_valid = 1'b0;
    checkOutput("abort_pre_err", 32'(err), 1);
    ld_valid = 1'b1;
    ld_addr  = 32'h10;
    ld_data  = 32'hdead_beef;
    abort    = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    abort    = 1'b0;
    checkReset("abort_load");
    @(negedge clk);
    checkOutput("abort_stays_idle", 32'(imem_we), 0);
    applyStimulus(1'b1, 1'b0);
    checkFill();

    // Asynchronous reset mid-RUN.
    prog.delete();
    prog.push_back('{32'd0, 32'h1234_5678, 1'b1, 1'b1, 1'b0});
    runLoad();
    cpu_pc = 32'd0;
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_cycles", cycles, 5);
    #2 rst = 1'b0;
    #1 checkReset("rst_run");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle_we", 32'(imem_we), 0);
    checkOutput("post_rst_idle_rstn", 32'(cpu_rst_n), 0);

    // Asynchronous reset mid-FILL, then mid-LOAD.
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("midfill_we", 32'(imem_we), 1);
    checkOutput("midfill_addr", imem_addr, 32'd12);
    #2 rst = 1'b0;
    #1 checkReset("rst_fill");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkFill();
    ld_valid = 1'b1;
    ld_addr  = 32'd3;
    @(negedge clk);
    ld_valid = 1'b0;
    checkOutput("midload_err", 32'(err), 1);
    #2 rst = 1'b0;
    #1 checkReset("rst_load");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
